// File: rtl/cp0_reg_pkg.sv
// Shared CP0 constants: register addresses, exception-type codes and field positions.
// Exception decoding lives here so the register file and any future consumer agree on codes.
package cp0_reg_pkg;

  localparam logic [4:0] CP0_REG_COUNT   = 5'd9;
  localparam logic [4:0] CP0_REG_COMPARE = 5'd11;
  localparam logic [4:0] CP0_REG_STATUS  = 5'd12;
  localparam logic [4:0] CP0_REG_CAUSE   = 5'd13;
  localparam logic [4:0] CP0_REG_EPC     = 5'd14;
  localparam logic [4:0] CP0_REG_PRID    = 5'd15;
  localparam logic [4:0] CP0_REG_CONFIG  = 5'd16;

  localparam logic [31:0] EXC_INT          = 32'h0000_0001;
  localparam logic [31:0] EXC_SYSCALL      = 32'h0000_0008;
  localparam logic [31:0] EXC_INST_INVALID = 32'h0000_000a;
  localparam logic [31:0] EXC_OV           = 32'h0000_000c;
  localparam logic [31:0] EXC_TRAP         = 32'h0000_000d;
  localparam logic [31:0] EXC_ERET         = 32'h0000_000e;

  localparam int STATUS_EXL     = 1;
  localparam int CAUSE_BD       = 31;
  localparam int CAUSE_IP_HI    = 15;
  localparam int CAUSE_IP_LO    = 10;
  localparam int CAUSE_EXC_HI   = 6;
  localparam int CAUSE_EXC_LO   = 2;

  // Software may only touch IV, WP and the two software-interrupt IP bits
  localparam logic [31:0] CAUSE_WR_MASK = 32'h00C0_0300;

  typedef struct packed {
    logic       valid;
    logic [4:0] code;
  } exc_decode_t;

  function automatic exc_decode_t decodeExc(input logic [31:0] excType);
    exc_decode_t d;
    d.valid = 1'b1;
    d.code  = 5'd0;
    case (excType)
      EXC_INT:          d.code = 5'd0;
      EXC_SYSCALL:      d.code = 5'd8;
      EXC_INST_INVALID: d.code = 5'd10;
      EXC_OV:           d.code = 5'd12;
      EXC_TRAP:         d.code = 5'd13;
      default:          d.valid = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/cp0_reg_if.sv
// CP0 port bundle: WB write port, EX read port, MEM exception inputs and live register outputs.
interface cp0_reg_if;

  logic        we_i;
  logic [4:0]  waddr_i;
  logic [31:0] data_i;
  logic [4:0]  raddr_i;
  logic [31:0] data_o;
  logic [5:0]  int_i;
  logic [31:0] excepttype_i;
  logic [31:0] current_inst_addr_i;
  logic        is_in_delayslot_i;
  logic [31:0] count_o;
  logic [31:0] compare_o;
  logic [31:0] status_o;
  logic [31:0] cause_o;
  logic [31:0] epc_o;
  logic [31:0] config_o;
  logic [31:0] prid_o;
  logic        timer_int_o;

  modport master (
    output we_i, waddr_i, data_i, raddr_i, int_i,
           excepttype_i, current_inst_addr_i, is_in_delayslot_i,
    input  data_o, count_o, compare_o, status_o, cause_o,
           epc_o, config_o, prid_o, timer_int_o
  );

  modport slave (
    input  we_i, waddr_i, data_i, raddr_i, int_i,
           excepttype_i, current_inst_addr_i, is_in_delayslot_i,
    output data_o, count_o, compare_o, status_o, cause_o,
           epc_o, config_o, prid_o, timer_int_o
  );

endinterface

// File: rtl/cp0_reg_timer.sv
// cp0_timer: free-running Count, Compare and the level timer interrupt they raise.
module cp0_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_countWe,
  input  logic        i_compareWe,
  input  logic [31:0] i_data,
  output logic [31:0] o_count,
  output logic [31:0] o_compare,
  output logic        o_timerInt
);

  logic [31:0] r_count;
  logic [31:0] r_compare;
  logic        r_timerInt;

  // A Compare write acknowledges the interrupt and takes priority over a fresh match
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count    <= 32'd0;
      r_compare  <= 32'd0;
      r_timerInt <= 1'b0;
    end else begin
      r_count <= i_countWe ? i_data : r_count + 32'd1;
      if (i_compareWe) begin
        r_compare  <= i_data;
        r_timerInt <= 1'b0;
      end else if (r_compare != 32'd0 && r_count == r_compare) begin
        r_timerInt <= 1'b1;
      end
    end
  end

  assign o_count    = r_count;
  assign o_compare  = r_compare;
  assign o_timerInt = r_timerInt;

endmodule

// File: rtl/cp0_reg.sv
// cp0_reg: CP0 register file (Status/Cause/EPC plus constant PRId/Config) with exception entry/return.
// Define CP0_TIMER_EN to build Count/Compare and the timer interrupt; otherwise they read as 0.
module cp0_reg
  import cp0_reg_pkg::*;
#(
  parameter logic [31:0] PRID_VALUE   = 32'h004c_0102,
  parameter logic [31:0] CONFIG_VALUE = 32'h0000_8000,
  parameter logic [31:0] STATUS_RESET = 32'h1000_0000
) (
  input logic       clk,
  input logic       rst,
  cp0_reg_if.slave  bus
);

  logic [31:0] r_status;
  logic [31:0] r_cause;
  logic [31:0] r_epc;
  logic [31:0] w_count;
  logic [31:0] w_compare;
  logic        w_timerInt;
  logic [31:0] w_statusNext;
  logic [31:0] w_causeNext;
  logic [31:0] w_epcNext;
  logic [31:0] w_readData;
  exc_decode_t w_exc;

`ifdef CP0_TIMER_EN
  cp0_timer u_timer (
    .clk         (clk),
    .rst         (rst),
    .i_countWe   (bus.we_i && bus.waddr_i == CP0_REG_COUNT),
    .i_compareWe (bus.we_i && bus.waddr_i == CP0_REG_COMPARE),
    .i_data      (bus.data_i),
    .o_count     (w_count),
    .o_compare   (w_compare),
    .o_timerInt  (w_timerInt)
  );
`else
  assign w_count    = 32'd0;
  assign w_compare  = 32'd0;
  assign w_timerInt = 1'b0;
`endif

  // Write port first, then the exception overlays it so exception fields win
  always_comb begin
    w_exc        = decodeExc(bus.excepttype_i);
    w_statusNext = r_status;
    w_causeNext  = r_cause;
    w_epcNext    = r_epc;
    w_causeNext[CAUSE_IP_HI:CAUSE_IP_LO] = bus.int_i;

    if (bus.we_i) begin
      case (bus.waddr_i)
        CP0_REG_STATUS: w_statusNext = bus.data_i;
        CP0_REG_CAUSE:  w_causeNext  = (w_causeNext & ~CAUSE_WR_MASK) | (bus.data_i & CAUSE_WR_MASK);
        CP0_REG_EPC:    w_epcNext    = bus.data_i;
        default: ;
      endcase
    end

    if (bus.excepttype_i == EXC_ERET) begin
      w_statusNext[STATUS_EXL] = 1'b0;
    end else if (w_exc.valid) begin
      // A nested exception keeps the outer EPC/BD so the original return point survives
      if (!w_statusNext[STATUS_EXL]) begin
        if (bus.is_in_delayslot_i) begin
          w_epcNext             = bus.current_inst_addr_i - 32'd4;
          w_causeNext[CAUSE_BD] = 1'b1;
        end else begin
          w_epcNext             = bus.current_inst_addr_i;
          w_causeNext[CAUSE_BD] = 1'b0;
        end
        w_statusNext[STATUS_EXL] = 1'b1;
      end
      w_causeNext[CAUSE_EXC_HI:CAUSE_EXC_LO] = w_exc.code;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_status <= STATUS_RESET;
      r_cause  <= 32'd0;
      r_epc    <= 32'd0;
    end else begin
      r_status <= w_statusNext;
      r_cause  <= w_causeNext;
      r_epc    <= w_epcNext;
    end
  end

  always_comb begin
    w_readData = 32'd0;
    case (bus.raddr_i)
      CP0_REG_COUNT:   w_readData = w_count;
      CP0_REG_COMPARE: w_readData = w_compare;
      CP0_REG_STATUS:  w_readData = r_status;
      CP0_REG_CAUSE:   w_readData = r_cause;
      CP0_REG_EPC:     w_readData = r_epc;
      CP0_REG_PRID:    w_readData = PRID_VALUE;
      CP0_REG_CONFIG:  w_readData = CONFIG_VALUE;
      default: ;
    endcase
  end

  assign bus.data_o      = w_readData;
  assign bus.count_o     = w_count;
  assign bus.compare_o   = w_compare;
  assign bus.status_o    = r_status;
  assign bus.cause_o     = r_cause;
  assign bus.epc_o       = r_epc;
  assign bus.config_o    = CONFIG_VALUE;
  assign bus.prid_o      = PRID_VALUE;
  assign bus.timer_int_o = w_timerInt;

endmodule
